// File: rtl/shufflenet_layer_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflenet_layer_seq_if : job, memory and datapath-control bundle          |
// | perf_cycles exists only when SEQ_PERF_CNT_EN is defined                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface shufflenet_layer_seq_if;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_height;
  logic [15:0] cfg_in_base;
  logic [15:0] cfg_out_base;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        CU_Save;
  logic        CU_CLR;
  logic        CIB_Shift;
  logic        CIB_Zero_Input;
  logic [2:0]  CIB_Size;
  logic [1:0]  CL_Out_Sel;
  logic        MPB_In_Ready;
  logic        MPB_Out_Ready;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  modport master (
    output start, cfg_mode, cfg_width, cfg_height, cfg_in_base, cfg_out_base, out_ready,
`ifdef SEQ_PERF_CNT_EN
    input  perf_cycles,
`endif
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr,
    input  CU_Save, CU_CLR, CIB_Shift, CIB_Zero_Input, CIB_Size, CL_Out_Sel,
    input  MPB_In_Ready, MPB_Out_Ready
  );

  modport slave (
    input  start, cfg_mode, cfg_width, cfg_height, cfg_in_base, cfg_out_base, out_ready,
`ifdef SEQ_PERF_CNT_EN
    output perf_cycles,
`endif
    output busy, done, rd_en, rd_addr, wr_en, wr_addr,
    output CU_Save, CU_CLR, CIB_Shift, CIB_Zero_Input, CIB_Size, CL_Out_Sel,
    output MPB_In_Ready, MPB_Out_Ready
  );
endinterface
`default_nettype wire

// File: rtl/shufflenet_layer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflenet_layer_seq : per-pixel tap sequencer for conv/maxpool/add/pw     |
// | Optional busy-cycle counter enabled by defining SEQ_PERF_CNT_EN            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shufflenet_layer_seq (
  input wire                    clk,
  input wire                    rst,
  shufflenet_layer_seq_if.slave bus
);
  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_DRAIN = 3'd2;
  localparam logic [2:0] c_SAVE  = 3'd3;
  localparam logic [2:0] c_WRITE = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [1:0] c_MODE_CONV = 2'b00;
  localparam logic [1:0] c_MODE_POOL = 2'b01;
  localparam logic [1:0] c_MODE_ADD  = 2'b10;
  localparam logic [1:0] c_MODE_PW   = 2'b11;

  logic [2:0]  r_state;
  logic [1:0]  r_mode;
  logic [7:0]  r_width;
  logic [7:0]  r_height;
  logic [15:0] r_in_base;
  logic [15:0] r_out_base;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic [15:0] r_pix;
  logic [1:0]  r_dyi;
  logic [1:0]  r_dxi;
  logic [15:0] r_rd_addr;
  logic        r_shift;
  logic        r_zero;

  logic        w_is_3x3;
  logic [1:0]  w_tap_init;
  logic        w_first_tap;
  logic        w_last_tap;
  logic        w_last_pix;
  logic [9:0]  w_ty;
  logic [9:0]  w_tx;
  logic        w_inb;
  logic [15:0] w_tap_addr;
  logic        w_fetch;
  logic        w_rd_en;
  logic        w_busy;

  // Tap indices run 0..2 with 1 meaning offset 0; single-tap modes sit at the centre.
  assign w_is_3x3    = ~r_mode[1];
  assign w_tap_init  = r_mode[1] ? 2'd1 : 2'd0;
  assign w_first_tap = !w_is_3x3 || (r_dyi == 2'd0 && r_dxi == 2'd0);
  assign w_last_tap  = !w_is_3x3 || (r_dyi == 2'd2 && r_dxi == 2'd2);
  assign w_last_pix  = (r_col == r_width - 8'd1) && (r_row == r_height - 8'd1);

  // A negative coordinate wraps to a large unsigned value and fails the bound test.
  assign w_ty       = {2'b00, r_row} + {8'b0, r_dyi} - 10'd1;
  assign w_tx       = {2'b00, r_col} + {8'b0, r_dxi} - 10'd1;
  assign w_inb      = (w_ty < {2'b00, r_height}) && (w_tx < {2'b00, r_width});
  assign w_tap_addr = r_in_base + ({8'b0, w_ty[7:0]} * {8'b0, r_width}) + {8'b0, w_tx[7:0]};

  assign w_fetch = (r_state == c_FETCH);
  assign w_rd_en = w_fetch && w_inb;
  assign w_busy  = (r_state != c_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_mode     <= 2'b00;
      r_width    <= 8'd0;
      r_height   <= 8'd0;
      r_in_base  <= 16'd0;
      r_out_base <= 16'd0;
      r_row      <= 8'd0;
      r_col      <= 8'd0;
      r_pix      <= 16'd0;
      r_dyi      <= 2'd0;
      r_dxi      <= 2'd0;
      r_rd_addr  <= 16'd0;
      r_shift    <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_shift <= w_fetch;
      r_zero  <= w_fetch && !w_inb;
      if (w_rd_en) begin
        r_rd_addr <= w_tap_addr;
      end
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_mode     <= bus.cfg_mode;
            r_width    <= bus.cfg_width;
            r_height   <= bus.cfg_height;
            r_in_base  <= bus.cfg_in_base;
            r_out_base <= bus.cfg_out_base;
            r_row      <= 8'd0;
            r_col      <= 8'd0;
            r_pix      <= 16'd0;
            r_dyi      <= bus.cfg_mode[1] ? 2'd1 : 2'd0;
            r_dxi      <= bus.cfg_mode[1] ? 2'd1 : 2'd0;
            r_state    <= (bus.cfg_width == 8'd0 || bus.cfg_height == 8'd0) ? c_DONE : c_FETCH;
          end
        end
        c_FETCH: begin
          if (w_last_tap) begin
            r_state <= c_DRAIN;
          end else if (r_dxi == 2'd2) begin
            r_dxi <= 2'd0;
            r_dyi <= r_dyi + 2'd1;
          end else begin
            r_dxi <= r_dxi + 2'd1;
          end
        end
        c_DRAIN: r_state <= (r_mode == c_MODE_ADD) ? c_WRITE : c_SAVE;
        c_SAVE:  r_state <= c_WRITE;
        c_WRITE: begin
          if (bus.out_ready) begin
            if (w_last_pix) begin
              r_state <= c_DONE;
            end else begin
              r_state <= c_FETCH;
              r_pix   <= r_pix + 16'd1;
              r_dyi   <= w_tap_init;
              r_dxi   <= w_tap_init;
              if (r_col == r_width - 8'd1) begin
                r_col <= 8'd0;
                r_row <= r_row + 8'd1;
              end else begin
                r_col <= r_col + 8'd1;
              end
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.busy           = w_busy;
  assign bus.done           = (r_state == c_DONE);
  assign bus.rd_en          = w_rd_en;
  assign bus.rd_addr        = w_rd_en ? w_tap_addr : r_rd_addr;
  assign bus.wr_en          = (r_state == c_WRITE);
  assign bus.wr_addr        = (r_state == c_WRITE) ? (r_out_base + r_pix) : 16'd0;
  assign bus.CU_Save        = (r_state == c_SAVE) && (r_mode == c_MODE_CONV || r_mode == c_MODE_PW);
  assign bus.CU_CLR         = w_fetch && w_first_tap && (r_mode == c_MODE_CONV || r_mode == c_MODE_PW);
  assign bus.CIB_Shift      = r_shift;
  assign bus.CIB_Zero_Input = r_zero;
  assign bus.CIB_Size       = !w_busy ? 3'd0 : (w_is_3x3 ? 3'd3 : 3'd1);
  assign bus.CL_Out_Sel     = !w_busy ? 2'b00 :
                              (r_mode == c_MODE_POOL) ? 2'b01 :
                              (r_mode == c_MODE_ADD)  ? 2'b10 : 2'b00;
  assign bus.MPB_In_Ready   = r_shift && (r_mode == c_MODE_POOL);
  assign bus.MPB_Out_Ready  = (r_state == c_SAVE) && (r_mode == c_MODE_POOL);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= 32'd0;
    end else if (r_state == c_IDLE && bus.start) begin
      r_perf <= 32'd0;
    end else if (w_busy && r_perf != 32'hFFFF_FFFF) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf;
`endif
endmodule
`default_nettype wire

// File: tb/tb_shufflenet_layer_seq.sv
`default_nettype none
// tb_shufflenet_layer_seq: scoreboard bench; expected read/write addresses are queued at job start.
module tb_shufflenet_layer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  int   exp_done;

  shufflenet_layer_seq_if bus();
  shufflenet_layer_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: raster order, dy outer, bounds-filtered reads, one write per pixel.
  task automatic push_expected(input logic [1:0] mode, input int w, input int h,
                               input logic [15:0] ib, input logic [15:0] ob);
    int per;
    int ntap;
    rd_q.delete();
    wr_q.delete();
    per  = (mode == 2'b10) ? 3 : (mode == 2'b11) ? 4 : 12;
    ntap = mode[1] ? 1 : 9;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        for (int t = 0; t < ntap; t++) begin
          int y;
          int x;
          y = r + (mode[1] ? 0 : (t / 3 - 1));
          x = c + (mode[1] ? 0 : (t % 3 - 1));
          if (y >= 0 && y < h && x >= 0 && x < w) rd_q.push_back(16'(int'(ib) + y * w + x));
        end
        wr_q.push_back(16'(int'(ob) + r * w + c));
      end
    end
    exp_done = 1 + w * h * per;
  endtask

  // Leaves the bench in cycle 1 (just after the edge that sampled start), cfg scrambled.
  task automatic start_job(input logic [1:0] mode, input logic [7:0] w, input logic [7:0] h,
                           input logic [15:0] ib, input logic [15:0] ob);
    @(posedge clk); #1;
    bus.cfg_mode = mode; bus.cfg_width = w; bus.cfg_height = h;
    bus.cfg_in_base = ib; bus.cfg_out_base = ob; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cfg_mode = ~mode; bus.cfg_width = 8'hFF; bus.cfg_height = 8'hFF;
    bus.cfg_in_base = 16'hDEAD; bus.cfg_out_base = 16'hBEEF;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    bus.start = 0; bus.out_ready = 1; bus.cfg_mode = 0; bus.cfg_width = 0;
    bus.cfg_height = 0; bus.cfg_in_base = 0; bus.cfg_out_base = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {6'b0, bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.CU_Save, bus.CU_CLR,
           bus.CIB_Shift, bus.CIB_Zero_Input, bus.MPB_In_Ready, bus.MPB_Out_Ready};
    checks++; if (got !== 16'd0) begin failures++; $display("FAIL reset_bits got=%h exp=0", got); end
    checks++; if (bus.rd_addr !== 16'd0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
    checks++; if (bus.wr_addr !== 16'd0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); end
    checks++; if (bus.CIB_Size !== 3'd0 || bus.CL_Out_Sel !== 2'd0) begin
      failures++; $display("FAIL reset_sel size=%0d sel=%0d exp=0,0", bus.CIB_Size, bus.CL_Out_Sel); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_conv_1x1();
    logic [15:0] e;
    logic exp_shift;
    push_expected(2'b00, 1, 1, 16'h0100, 16'h0200);
    start_job(2'b00, 8'd1, 8'd1, 16'h0100, 16'h0200);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_shift = (c >= 2 && c <= 10);
      checks++; if (bus.CIB_Shift !== exp_shift || bus.CIB_Zero_Input !== (exp_shift && c != 6)) begin
        failures++; $display("FAIL conv_shift c=%0d got=%b%b exp=%b%b", c, bus.CIB_Shift, bus.CIB_Zero_Input, exp_shift, exp_shift && c != 6); end
      checks++; if (bus.CU_CLR !== (c == 1) || bus.CU_Save !== (c == 11)) begin
        failures++; $display("FAIL conv_cu c=%0d clr=%b save=%b", c, bus.CU_CLR, bus.CU_Save); end
      checks++; if (bus.rd_en !== (c == 5) || bus.wr_en !== (c == 12) || bus.done !== (c == 13)) begin
        failures++; $display("FAIL conv_timing c=%0d rd=%b wr=%b done=%b", c, bus.rd_en, bus.wr_en, bus.done); end
      checks++; if (bus.MPB_In_Ready !== 1'b0 || bus.CIB_Size !== ((c <= 13) ? 3'd3 : 3'd0)) begin
        failures++; $display("FAIL conv_sel c=%0d mpb=%b size=%0d", c, bus.MPB_In_Ready, bus.CIB_Size); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL conv_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL conv_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
    end
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL conv_leftover rd=%0d wr=%0d exp=0,0", rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_add_4x1();
    logic [15:0] e;
    push_expected(2'b10, 4, 1, 16'h0000, 16'h0040);
    start_job(2'b10, 8'd4, 8'd1, 16'h0000, 16'h0040);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== (c == exp_done) || bus.CU_Save !== 1'b0 || bus.CU_CLR !== 1'b0) begin
        failures++; $display("FAIL add_ctrl c=%0d done=%b save=%b clr=%b", c, bus.done, bus.CU_Save, bus.CU_CLR); end
      checks++; if (bus.CIB_Size !== ((c <= 13) ? 3'd1 : 3'd0) || bus.CL_Out_Sel !== ((c <= 13) ? 2'd2 : 2'd0)) begin
        failures++; $display("FAIL add_sel c=%0d size=%0d sel=%0d", c, bus.CIB_Size, bus.CL_Out_Sel); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL add_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL add_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
`ifdef SEQ_PERF_CNT_EN
      if (c >= 14) begin
        checks++; if (bus.perf_cycles !== 32'd13) begin
          failures++; $display("FAIL perf_cycles c=%0d got=%0d exp=13", c, bus.perf_cycles); end
      end
`endif
    end
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL add_leftover rd=%0d wr=%0d exp=0,0", rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_stall_2x2();
    logic [15:0] e;
    logic [15:0] prev_addr;
    logic prev_stalled;
    int stall_left;
    int wr_cycles;
    int shifts;
    int zeros;
    stall_left = 5; wr_cycles = 0; shifts = 0; zeros = 0; prev_stalled = 0; prev_addr = 0;
    push_expected(2'b00, 2, 2, 16'h0010, 16'h0080);
    exp_done = exp_done + 5;
    start_job(2'b00, 8'd2, 8'd2, 16'h0010, 16'h0080);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.wr_en && stall_left > 0) begin bus.out_ready = 0; stall_left--; end
      else bus.out_ready = 1;
      if (prev_stalled) begin
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== prev_addr || bus.rd_en !== 1'b0) begin
          failures++; $display("FAIL stall_hold c=%0d wr=%b addr=%h exp=1,%h rd=%b", c, bus.wr_en, bus.wr_addr, prev_addr, bus.rd_en); end
      end
      prev_stalled = bus.wr_en && !bus.out_ready;
      prev_addr    = bus.wr_addr;
      if (bus.wr_en) wr_cycles++;
      if (bus.CIB_Shift) shifts++;
      if (bus.CIB_Zero_Input) zeros++;
      checks++; if (bus.done !== (c == exp_done)) begin
        failures++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, bus.done, c == exp_done); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL stall_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL stall_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
    end
    bus.out_ready = 1;
    checks++; if (wr_cycles != 9 || shifts != 36 || zeros != 20) begin
      failures++; $display("FAIL stall_counts wr=%0d shift=%0d zero=%0d exp=9,36,20", wr_cycles, shifts, zeros); end
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL stall_leftover rd=%0d wr=%0d exp=0,0", rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_maxpool_3x2();
    logic [15:0] e;
    int outs;
    outs = 0;
    push_expected(2'b01, 3, 2, 16'h1000, 16'h2000);
    start_job(2'b01, 8'd3, 8'd2, 16'h1000, 16'h2000);
    for (int c = 1; c <= 76; c++) begin
      @(negedge clk);
      if (bus.MPB_Out_Ready) outs++;
      checks++; if (bus.MPB_In_Ready !== bus.CIB_Shift || bus.CU_CLR !== 1'b0 || bus.CU_Save !== 1'b0) begin
        failures++; $display("FAIL pool_ctrl c=%0d mpbin=%b shift=%b clr=%b save=%b", c, bus.MPB_In_Ready, bus.CIB_Shift, bus.CU_CLR, bus.CU_Save); end
      checks++; if (bus.done !== (c == exp_done) || bus.CL_Out_Sel !== ((c <= exp_done) ? 2'd1 : 2'd0)) begin
        failures++; $display("FAIL pool_done c=%0d done=%b sel=%0d", c, bus.done, bus.CL_Out_Sel); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL pool_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL pool_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
    end
    checks++; if (outs != 6 || rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL pool_counts outs=%0d rd=%0d wr=%0d exp=6,0,0", outs, rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_pointwise_wrap();
    logic [15:0] e;
    int clrs;
    int saves;
    clrs = 0; saves = 0;
    push_expected(2'b11, 2, 2, 16'hFFF0, 16'hFFFE);
    start_job(2'b11, 8'd2, 8'd2, 16'hFFF0, 16'hFFFE);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.CU_CLR) clrs++;
      if (bus.CU_Save) saves++;
      checks++; if (bus.done !== (c == exp_done) || bus.CIB_Size !== ((c <= exp_done) ? 3'd1 : 3'd0) || bus.MPB_In_Ready !== 1'b0) begin
        failures++; $display("FAIL pw_ctrl c=%0d done=%b size=%0d mpb=%b", c, bus.done, bus.CIB_Size, bus.MPB_In_Ready); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL pw_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL pw_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
    end
    checks++; if (clrs != 4 || saves != 4 || rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL pw_counts clr=%0d save=%0d rd=%0d wr=%0d exp=4,4,0,0", clrs, saves, rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_abort();
    logic [15:0] e;
    logic [15:0] bits;
    start_job(2'b00, 8'd2, 8'd2, 16'h0000, 16'h0300);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 26) rst = 1;
      if (c == 27) begin
        rst = 0;
        bits = {6'b0, bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.CU_Save, bus.CU_CLR,
                bus.CIB_Shift, bus.CIB_Zero_Input, bus.MPB_In_Ready, bus.MPB_Out_Ready};
        checks++; if (bits !== 16'd0 || bus.rd_addr !== 16'd0 || bus.wr_addr !== 16'd0 ||
                      bus.CIB_Size !== 3'd0 || bus.CL_Out_Sel !== 2'd0) begin
          failures++; $display("FAIL abort_outputs bits=%h rd=%h wr=%h size=%0d sel=%0d exp=all 0", bits, bus.rd_addr, bus.wr_addr, bus.CIB_Size, bus.CL_Out_Sel); end
      end
      checks++; if (bus.done !== 1'b0 || (c >= 27 && bus.busy !== 1'b0)) begin
        failures++; $display("FAIL abort_done c=%0d done=%b busy=%b exp=0", c, bus.done, bus.busy); end
    end
    push_expected(2'b00, 2, 2, 16'h0500, 16'h0600);
    start_job(2'b00, 8'd2, 8'd2, 16'h0500, 16'h0600);
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== (c == exp_done)) begin
        failures++; $display("FAIL rerun_done c=%0d got=%b exp=%b", c, bus.done, c == exp_done); end
      if (bus.rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        checks++; if (bus.rd_addr !== e) begin failures++; $display("FAIL rerun_rd_addr got=%h exp=%h", bus.rd_addr, e); end
      end
      if (bus.wr_en && bus.out_ready) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checks++; if (bus.wr_addr !== e) begin failures++; $display("FAIL rerun_wr_addr got=%h exp=%h", bus.wr_addr, e); end
      end
    end
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL rerun_leftover rd=%0d wr=%0d exp=0,0", rd_q.size(), wr_q.size()); end
  endtask

  task automatic test_zero_and_held_start();
    int dones;
    int wrs;
    int done_cycle;
    @(posedge clk); #1;
    bus.cfg_mode = 2'b00; bus.cfg_width = 8'd0; bus.cfg_height = 8'd5;
    bus.cfg_in_base = 16'h0; bus.cfg_out_base = 16'h0; bus.start = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      failures++; $display("FAIL zero_done done=%b busy=%b rd=%b wr=%b exp=1,1,0,0", bus.done, bus.busy, bus.rd_en, bus.wr_en); end
    bus.start = 0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL zero_idle busy=%b done=%b exp=0,0", bus.busy, bus.done); end
    // Second job: start stays high for the whole job and is dropped on done.
    dones = 0; wrs = 0; done_cycle = 0;
    @(posedge clk); #1;
    bus.cfg_mode = 2'b10; bus.cfg_width = 8'd1; bus.cfg_height = 8'd1;
    bus.cfg_in_base = 16'h0007; bus.cfg_out_base = 16'h0009; bus.start = 1;
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.wr_en && bus.out_ready) wrs++;
      if (bus.done) begin dones++; done_cycle = c; bus.start = 0; end
    end
    bus.start = 0;
    checks++; if (dones != 1 || wrs != 1 || done_cycle != 4) begin
      failures++; $display("FAIL held_start dones=%0d wrs=%0d done_cycle=%0d exp=1,1,4", dones, wrs, done_cycle); end
  endtask

  initial begin
    bus.start = 0;
    bus.out_ready = 1;
    test_reset();
    test_conv_1x1();
    test_add_4x1();
    test_stall_2x2();
    test_maxpool_3x2();
    test_pointwise_wrap();
    test_abort();
    test_zero_and_held_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/shufflenet_layer_seq.md
SHUFFLENET_LAYER_SEQ -- requirements
Module: shufflenet_layer_seq

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: CLK input 1 (rising-edge clock), RST input 1 (synchronous, active-high).
REQ-002 SHALL have: start input 1 (job request, sampled in IDLE only); cfg_mode input 2 (00 conv3x3, 01 maxpool3x3, 10 add, 11 pointwise); cfg_width input 8; cfg_height input 8; cfg_in_base input 16; cfg_out_base input 16; out_ready input 1 (write accept).
REQ-003 SHALL have: busy output 1; done output 1 (single-cycle pulse); rd_en output 1; rd_addr output 16; wr_en output 1; wr_addr output 16.
REQ-004 SHALL have datapath controls: CU_Save output 1; CU_CLR output 1; CIB_Shift output 1; CIB_Zero_Input output 1; CIB_Size output 3; CL_Out_Sel output 2; MPB_In_Ready output 1; MPB_Out_Ready output 1.

Function
REQ-005 SHALL use states IDLE, FETCH, DRAIN, SAVE, WRITE, DONE; IDLE->FETCH on start; IDLE->DONE on start when cfg_width==0 or cfg_height==0; DONE->IDLE always.
REQ-006 SHALL latch all cfg_* inputs on the start cycle; later cfg changes have no effect until the next job.
REQ-007 SHALL ignore start while busy; busy=1 in every state except IDLE.
REQ-008 SHALL visit pixels in raster order (col fastest), one pass per pixel: FETCH, DRAIN, SAVE (modes 00/01/11 only), WRITE.
REQ-009 Taps per pixel: 9 for modes 00/01 (dy,dx in -1..1, dy outer), 1 for modes 10/11; FETCH lasts exactly one cycle per tap.
REQ-010 In-bounds tap: rd_en=1, rd_addr=in_base+(row+dy)*width+(col+dx), mod 2^16.
REQ-011 Out-of-bounds tap: rd_en=0, rd_addr holds; CIB_Zero_Input=1 in that tap's aligned cycle.
REQ-012 Read latency is 1: CIB_Shift asserted one cycle after each tap's FETCH cycle (last one lands in DRAIN); CIB_Zero_Input is aligned to CIB_Shift.
REQ-013 MPB_In_Ready SHALL equal CIB_Shift in mode 01 and be 0 otherwise.
REQ-014 CU_CLR=1 during the first FETCH cycle of each pixel in modes 00/11.
REQ-015 SAVE lasts one cycle: CU_Save=1 in modes 00/11; MPB_Out_Ready=1 in mode 01.
REQ-016 WRITE: wr_en=1 and wr_addr=out_base+pixel_index until out_ready=1; transfer completes on the cycle wr_en&&out_ready; no FETCH for the next pixel before that.
REQ-017 After the last pixel's write completes, go to DONE; done=1 for exactly that cycle.
REQ-018 CL_Out_Sel SHALL equal 00 for modes 00/11, 01 for mode 01, 10 for mode 10; CIB_Size=3 for modes 00/01, 1 otherwise; both held from start to DONE inclusive.
REQ-019 Per-pixel cycles with out_ready=1: 12 (modes 00/01), 4 (mode 11), 3 (mode 10).
REQ-020 Row/col counters SHALL be 8-bit; pixel_index 16-bit; width*height up to 65025 with no overflow.

Reset
REQ-021 RST=1 at any clock edge, including mid-job, SHALL force IDLE and clear counters; no done pulse is issued for an aborted job.
REQ-022 Reset values SHALL be: all 1-bit outputs 0, rd_addr=0, wr_addr=0, CIB_Size=0, CL_Out_Sel=0.

Configuration
REQ-023 With SEQ_PERF_CNT_EN defined: add output perf_cycles 32 bits, cleared on start, incremented each busy cycle, held in IDLE, saturating at 0xFFFFFFFF; cleared by reset. Without the macro: no port, no counter logic.

Verification
REQ-024 Mode 00, 1x1 map, in_base=0x100, out_base=0x200, start at cycle 0, out_ready=1 -> exactly one rd_en (cycle 5, addr 0x100); 9 CIB_Shift pulses at cycles 2-10, CIB_Zero_Input on 8 of them (all except cycle 6); CU_CLR at 1; CU_Save at 11; wr_en at 12 with addr 0x200; done at 13.
REQ-025 Mode 10, 4x1 map, in_base=0, out_base=0x40, out_ready=1 -> rd_addr 0,1,2,3; wr_addr 0x40-0x43; no CU_Save; done at cycle 13.
REQ-026 Mode 00, 2x2 map, out_ready=0 for 5 cycles at the first WRITE -> wr_en and wr_addr stable for 6 cycles, no rd_en meanwhile; done at cycle 54.
REQ-027 RST pulsed during FETCH of pixel 2 -> next cycle all outputs at reset values, no done; a new start runs the job normally.
REQ-028 cfg_width=0, start -> done at cycle 1, no rd_en/wr_en; start held high during busy -> one job only.
REQ-029 With SEQ_PERF_CNT_EN, mode 10 4x1 job -> perf_cycles=13 after done, stable in IDLE.
